debug_send_scheduler: RTL

- Shares one 40-bit debug serial sender between NUM_REQ on-chip requesters.
- Uses round-robin arbitration and tags each word with the requester index.
- Sequences the sender's store/busy handshake: issue one store, wait for accept, wait for drain, then serve the next requester.
- Sits in the in_clk domain, directly in front of the debug sender's store/data/in_state_out pins.

---
 rtl/debug_send_scheduler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/debug_send_scheduler.sv
// Round-robin scheduler sharing one debug serial sender between NUM_REQ
// requesters. Tags each word with the requester index and sequences the
// sender's store/busy handshake: one store, wait for accept, wait for drain.
module debug_send_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 40,
  parameter int unsigned ID_W           = 3,
  parameter int unsigned ACCEPT_TIMEOUT = 255
) (
  input  logic                      in_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      store,
  output logic [DATA_W-1:0]         data_out,
  input  logic                      sender_busy,
  input  logic                      clr_err,
  output logic                      timeout_err,
  output logic [15:0]               sent_count,
  output logic                      active
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned IW    = PTR_W + 1;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned PAY_W = DATA_W - ID_W;

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_ISSUE       = 2'd1;
  localparam logic [1:0] S_WAIT_ACCEPT = 2'd2;
  localparam logic [1:0] S_WAIT_DRAIN  = 2'd3;

  localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(ACCEPT_TIMEOUT);
  localparam logic [15:0]      COUNT_MAX = 16'hFFFF;
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [1:0]         state, state_next;
  logic [PTR_W-1:0]   ptr, ptr_next;
  logic [PTR_W-1:0]   grant, grant_next;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_next;
  logic [NUM_REQ-1:0] ack_next;
  logic               store_next;
  logic [DATA_W-1:0]  data_next;
  logic               err_next;
  logic [15:0]        count_next;

  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic               found_c;
  logic [PTR_W-1:0]   pick_c;
  logic [DATA_W-1:0]  pick_data_c;
  logic [IW-1:0]      idx_c;

  // Unflatten the requester payload bus
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  // First requesting index at or after the pointer, wrapping modulo NUM_REQ
  always_comb begin
    found_c     = 1'b0;
    pick_c      = '0;
    pick_data_c = '0;
    idx_c       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_c = {1'b0, ptr} + IW'(k);
      if (idx_c >= IW'(NUM_REQ)) begin
        idx_c = idx_c - IW'(NUM_REQ);
      end
      if (!found_c && req[idx_c[PTR_W-1:0]]) begin
        found_c     = 1'b1;
        pick_c      = idx_c[PTR_W-1:0];
        pick_data_c = data_arr[idx_c[PTR_W-1:0]];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    grant_next    = grant;
    wait_cnt_next = wait_cnt;
    ack_next      = '0;
    store_next    = 1'b0;
    data_next     = data_out;
    count_next    = sent_count;
    err_next      = clr_err ? 1'b0 : timeout_err;

    case (state)
      S_IDLE: begin
        if (found_c && !sender_busy) begin
          state_next       = S_ISSUE;
          grant_next       = pick_c;
          ack_next[pick_c] = 1'b1;
          store_next       = 1'b1;
          data_next        = {ID_W'(pick_c), pick_data_c[PAY_W-1:0]};
        end
      end
      S_ISSUE: begin
        ptr_next      = (grant == LAST_IDX) ? '0 : grant + PTR_W'(1);
        wait_cnt_next = '0;
        state_next    = S_WAIT_ACCEPT;
      end
      S_WAIT_ACCEPT: begin
        if (sender_busy) begin
          if (sent_count != COUNT_MAX) begin
            count_next = sent_count + 16'd1;
          end
          state_next = S_WAIT_DRAIN;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
          if (wait_cnt_next == TIMEOUT) begin
            err_next   = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_WAIT_DRAIN: begin
        if (!sender_busy) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register; active mirrors the registered state
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      active <= 1'b0;
    end else begin
      state  <= state_next;
      active <= (state_next != S_IDLE);
    end
  end

  // Datapath and output registers
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr         <= '0;
      grant       <= '0;
      wait_cnt    <= '0;
      ack         <= '0;
      store       <= 1'b0;
      data_out    <= '0;
      timeout_err <= 1'b0;
      sent_count  <= '0;
    end else begin
      ptr         <= ptr_next;
      grant       <= grant_next;
      wait_cnt    <= wait_cnt_next;
      ack         <= ack_next;
      store       <= store_next;
      data_out    <= data_next;
      timeout_err <= err_next;
      sent_count  <= count_next;
    end
  end

endmodule
